id_ex_reg: RTL and testbench
============================

ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32: datapath width of register data, PC and immediate fields.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port StallE  input  1  hold all E-stage state when high.
REQ-005 SHALL have port FlushE  input  1  insert a bubble at the next edge when high.
REQ-006 SHALL have ports RD1D, RD2D  input  WIDTH  register-file read data; RD1E, RD2E  output  WIDTH  registered copies (RD1E feeds the SrcAE forwarding mux).
REQ-007 SHALL have ports PCD, PCPlus4D, ImmExtD  input  WIDTH; PCE, PCPlus4E, ImmExtE  output  WIDTH  registered copies.
REQ-008 SHALL have ports Rs1D, Rs2D, RdD  input  5; Rs1E, Rs2E, RdE  output  5  register indices for the hazard unit.
REQ-009 SHALL have ports RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD  input  1; matching *E outputs  output  1.
REQ-010 SHALL have ports ResultSrcD  input  2 / ResultSrcE  output  2, and ALUControlD  input  3 / ALUControlE  output  3.
REQ-011 SHALL have port ValidE  output  1  high when E stage holds a real instruction.
REQ-012 SHALL have port BubbleCountE  output  32  present only under IDEX_PERF_CNT_EN (REQ-022).

Function
REQ-013 SHALL update every output exactly one clk edge after its D input is sampled; no combinational D-to-E path.
REQ-014 SHALL apply per-edge priority rst > FlushE > StallE > load.
REQ-015 SHALL on load (no rst, FlushE=0, StallE=0) capture every D input into its E output and set ValidE=1.
REQ-016 SHALL on StallE=1 (FlushE=0) hold all E outputs and ValidE unchanged, for any number of cycles.
REQ-017 SHALL on FlushE=1 drive RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE, ValidE to 0 and Rs1E, Rs2E, RdE to 0, regardless of StallE.
REQ-018 SHALL on FlushE zero RD1E, RD2E, PCE, PCPlus4E, ImmExtE so a bubble is fully deterministic.
REQ-019 SHALL guarantee a bubble has no architectural effect: RdE=0 ensures forwarding never matches a bubble, RegWriteE=MemWriteE=0 blocks writes.
REQ-020 SHALL treat simultaneous FlushE=1 and StallE=1 as flush (load-use stall of D with bubble into E).

Reset
REQ-021 SHALL on rst=1 at a rising edge set every output, including ValidE and BubbleCountE, to 0; rst mid-stall or mid-flush discards held state; first load follows the first edge with rst=0.

Configuration
REQ-022 SHALL, with IDEX_PERF_CNT_EN defined, provide a 32-bit BubbleCountE that increments by 1 on each edge where rst=0 and FlushE=1, holds otherwise (including during StallE), saturates at 32'hFFFFFFFF, and resets to 0.
REQ-023 SHALL, without IDEX_PERF_CNT_EN, omit BubbleCountE and its counter entirely; all other behaviour identical.

Verification
REQ-024 SHALL cover load: RD1D=32'hDEADBEEF, RdD=5, RegWriteD=1, StallE=FlushE=0 -> next edge RD1E=32'hDEADBEEF, RdE=5, RegWriteE=1, ValidE=1.
REQ-025 SHALL cover stall: load RD1D=32'h11, then StallE=1 for 3 cycles with RD1D=32'h22 -> RD1E stays 32'h11 for 3 cycles, becomes 32'h22 one edge after StallE drops.
REQ-026 SHALL cover flush with stall: E holds RegWriteE=1, RdE=7; assert FlushE=1, StallE=1 -> next edge RegWriteE=0, RdE=0, ValidE=0, RD1E=0.
REQ-027 SHALL cover reset mid-operation: E loaded with MemWriteE=1, PCE=32'h100; rst=1 for one edge with StallE=1 -> all outputs 0; first edge after rst=0 loads D inputs.
REQ-028 SHALL cover counter (macro defined): 5 flush cycles, 2 stall cycles, 3 flush cycles -> BubbleCountE=8; force counter to 32'hFFFFFFFF, flush once -> stays 32'hFFFFFFFF.

Source files
------------

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: captures decode-stage operands and control into the execute stage.
// Optional bubble counter (BubbleCountE) is built only when IDEX_PERF_CNT_EN is defined.
module id_ex_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             StallE,
  input  logic             FlushE,
  input  logic [WIDTH-1:0] RD1D,
  input  logic [WIDTH-1:0] RD2D,
  input  logic [WIDTH-1:0] PCD,
  input  logic [WIDTH-1:0] PCPlus4D,
  input  logic [WIDTH-1:0] ImmExtD,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdD,
  input  logic             RegWriteD,
  input  logic             MemWriteD,
  input  logic             JumpD,
  input  logic             BranchD,
  input  logic             ALUSrcD,
  input  logic [1:0]       ResultSrcD,
  input  logic [2:0]       ALUControlD,
  output logic [WIDTH-1:0] RD1E,
  output logic [WIDTH-1:0] RD2E,
  output logic [WIDTH-1:0] PCE,
  output logic [WIDTH-1:0] PCPlus4E,
  output logic [WIDTH-1:0] ImmExtE,
  output logic [4:0]       Rs1E,
  output logic [4:0]       Rs2E,
  output logic [4:0]       RdE,
  output logic             RegWriteE,
  output logic             MemWriteE,
  output logic             JumpE,
  output logic             BranchE,
  output logic             ALUSrcE,
  output logic [1:0]       ResultSrcE,
  output logic [2:0]       ALUControlE,
  output logic             ValidE
`ifdef IDEX_PERF_CNT_EN
  ,output logic [31:0]     BubbleCountE
`endif
);

  // A flush wins over a stall: the bubble is fully zeroed so RdE=0 never matches forwarding.
  always_ff @(posedge clk) begin
    if (rst || FlushE) begin
      RD1E        <= '0;
      RD2E        <= '0;
      PCE         <= '0;
      PCPlus4E    <= '0;
      ImmExtE     <= '0;
      Rs1E        <= '0;
      Rs2E        <= '0;
      RdE         <= '0;
      RegWriteE   <= 1'b0;
      MemWriteE   <= 1'b0;
      JumpE       <= 1'b0;
      BranchE     <= 1'b0;
      ALUSrcE     <= 1'b0;
      ResultSrcE  <= '0;
      ALUControlE <= '0;
      ValidE      <= 1'b0;
    end else if (!StallE) begin
      RD1E        <= RD1D;
      RD2E        <= RD2D;
      PCE         <= PCD;
      PCPlus4E    <= PCPlus4D;
      ImmExtE     <= ImmExtD;
      Rs1E        <= Rs1D;
      Rs2E        <= Rs2D;
      RdE         <= RdD;
      RegWriteE   <= RegWriteD;
      MemWriteE   <= MemWriteD;
      JumpE       <= JumpD;
      BranchE     <= BranchD;
      ALUSrcE     <= ALUSrcD;
      ResultSrcE  <= ResultSrcD;
      ALUControlE <= ALUControlD;
      ValidE      <= 1'b1;
    end
  end

`ifdef IDEX_PERF_CNT_EN
  logic [31:0] bubble_cnt;

  // Saturating count of inserted bubbles; stalls do not advance it.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (FlushE && (bubble_cnt != 32'hFFFF_FFFF)) begin
      bubble_cnt <= bubble_cnt + 32'd1;
    end
  end

  assign BubbleCountE = bubble_cnt;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: vector table plus hand sequences through a scoreboard queue.
// Define IDEX_PERF_CNT_EN to also exercise the bubble counter.
module tb_id_ex_reg;

  typedef struct packed {
    logic [31:0] rd1, rd2, pc, pcp4, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        regwrite, memwrite, jump, branch, alusrc;
    logic [1:0]  resultsrc;
    logic [2:0]  alucontrol;
  } stage_t;

  typedef struct packed {
    stage_t e;
    logic   valid;
  } exp_t;

  typedef struct {
    logic   r, f, s;
    stage_t d;
    stage_t e;
    logic   v;
  } vec_t;

  logic clk, rst, StallE, FlushE;
  logic [31:0] RD1D, RD2D, PCD, PCPlus4D, ImmExtD;
  logic [31:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
  logic [4:0]  Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE;
  logic RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
  logic RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0] ResultSrcD, ResultSrcE;
  logic [2:0] ALUControlD, ALUControlE;
  logic ValidE;
`ifdef IDEX_PERF_CNT_EN
  logic [31:0] BubbleCountE;
  logic [31:0] exp_bc;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  exp_t sb[$];

  id_ex_reg #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE),
    .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD),
    .ALUSrcD(ALUSrcD), .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD),
    .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
    .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
    .ValidE(ValidE)
`ifdef IDEX_PERF_CNT_EN
    ,.BubbleCountE(BubbleCountE)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stage_t pat(input logic [7:0] k);
    stage_t p;
    p.rd1        = {4{k}} ^ 32'hA5A5_0000;
    p.rd2        = {4{~k}};
    p.pc         = {k, 24'h00_0100};
    p.pcp4       = {k, 24'h00_0100} + 32'd4;
    p.imm        = {k, 8'h3C, ~k, 8'hC3};
    p.rs1        = k[4:0];
    p.rs2        = ~k[4:0];
    p.rd         = k[4:0] ^ 5'h15;
    p.regwrite   = k[0];
    p.memwrite   = k[1];
    p.jump       = k[2];
    p.branch     = k[3];
    p.alusrc     = ~k[0];
    p.resultsrc  = k[1:0];
    p.alucontrol = k[2:0];
    return p;
  endfunction

  function automatic stage_t got_e();
    stage_t g;
    g.rd1 = RD1E; g.rd2 = RD2E; g.pc = PCE; g.pcp4 = PCPlus4E; g.imm = ImmExtE;
    g.rs1 = Rs1E; g.rs2 = Rs2E; g.rd = RdE;
    g.regwrite = RegWriteE; g.memwrite = MemWriteE; g.jump = JumpE;
    g.branch = BranchE; g.alusrc = ALUSrcE;
    g.resultsrc = ResultSrcE; g.alucontrol = ALUControlE;
    return g;
  endfunction

  // Drive one cycle, queue its expected E-stage result, then compare after the edge.
  task automatic step(input logic r, input logic f, input logic s, input stage_t d,
                      input stage_t e, input logic v, input string name);
    exp_t want, got;
    rst = r; FlushE = f; StallE = s;
    RD1D = d.rd1; RD2D = d.rd2; PCD = d.pc; PCPlus4D = d.pcp4; ImmExtD = d.imm;
    Rs1D = d.rs1; Rs2D = d.rs2; RdD = d.rd;
    RegWriteD = d.regwrite; MemWriteD = d.memwrite; JumpD = d.jump;
    BranchD = d.branch; ALUSrcD = d.alusrc;
    ResultSrcD = d.resultsrc; ALUControlD = d.alucontrol;
    sb.push_back({e, v});
`ifdef IDEX_PERF_CNT_EN
    if (r) exp_bc = 32'd0;
    else if (f && exp_bc != 32'hFFFF_FFFF) exp_bc = exp_bc + 32'd1;
`endif
    @(posedge clk);
    #1;
    n_checks++;
    if (sb.size() == 0) begin
      $display("FAIL %s: scoreboard empty, got nothing to compare, required an entry", name);
    end else begin
      want = sb.pop_front();
      got  = {got_e(), ValidE};
      if (got === want) n_pass++;
      else $display("FAIL %s: got e=%h valid=%b, required e=%h valid=%b",
                    name, got.e, got.valid, want.e, want.valid);
    end
`ifdef IDEX_PERF_CNT_EN
    n_checks++;
    if (BubbleCountE === exp_bc) n_pass++;
    else $display("FAIL %s bubble_count: got %h, required %h", name, BubbleCountE, exp_bc);
`endif
  endtask

  vec_t tbl[14];
  stage_t z, d, held;

  initial begin
    z = '0;
    rst = 1'b1; FlushE = 1'b0; StallE = 1'b0;
    RD1D = '0; RD2D = '0; PCD = '0; PCPlus4D = '0; ImmExtD = '0;
    Rs1D = '0; Rs2D = '0; RdD = '0;
    RegWriteD = 0; MemWriteD = 0; JumpD = 0; BranchD = 0; ALUSrcD = 0;
    ResultSrcD = '0; ALUControlD = '0;
`ifdef IDEX_PERF_CNT_EN
    exp_bc = '0;
`endif

    //           r     f     s     d               e               v
    tbl[0]  = '{1'b1, 1'b0, 1'b0, pat(8'h01),     z,              1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, pat(8'h01),     pat(8'h01),     1'b1};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, pat(8'h5E),     pat(8'h5E),     1'b1};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, pat(8'h33),     pat(8'h5E),     1'b1};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, pat(8'h44),     z,              1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, pat(8'hC7),     pat(8'hC7),     1'b1};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, pat(8'h66),     z,              1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, pat(8'h77),     z,              1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, '1,             '1,             1'b1};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, z,              z,              1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, pat(8'hFA),     pat(8'hFA),     1'b1};
    tbl[11] = '{1'b1, 1'b0, 1'b1, pat(8'h12),     z,              1'b0};
    tbl[12] = '{1'b1, 1'b1, 1'b0, pat(8'h23),     z,              1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, pat(8'h9B),     pat(8'h9B),     1'b1};

    for (int i = 0; i < 14; i++)
      step(tbl[i].r, tbl[i].f, tbl[i].s, tbl[i].d, tbl[i].e, tbl[i].v, $sformatf("vec%0d", i));

    // Basic load of a tagged instruction.
    d = pat(8'h20); d.rd1 = 32'hDEAD_BEEF; d.rd = 5'd5; d.regwrite = 1'b1;
    step(0, 0, 0, d, d, 1, "load_deadbeef");

    // Stall holds for three cycles, new data lands one edge after release.
    d = pat(8'h40); d.rd1 = 32'h11; held = d;
    step(0, 0, 0, d, held, 1, "stall_preload");
    d.rd1 = 32'h22;
    for (int i = 0; i < 3; i++) step(0, 0, 1, d, held, 1, $sformatf("stall_hold%0d", i));
    step(0, 0, 0, d, d, 1, "stall_release");

    // Flush with stall inserts a bubble.
    d = pat(8'h81); d.regwrite = 1'b1; d.rd = 5'd7;
    step(0, 0, 0, d, d, 1, "flushstall_preload");
    step(0, 1, 1, pat(8'h82), z, 0, "flushstall_bubble");

    // Reset while stalled discards held state; next edge loads.
    d = pat(8'hB4); d.memwrite = 1'b1; d.pc = 32'h100;
    step(0, 0, 0, d, d, 1, "rst_preload");
    step(1, 0, 1, pat(8'hB5), z, 0, "rst_midstall");
    step(0, 0, 0, pat(8'hB6), pat(8'hB6), 1, "rst_firstload");

`ifdef IDEX_PERF_CNT_EN
    step(1, 0, 0, z, z, 0, "cnt_reset");
    for (int i = 0; i < 5; i++) step(0, 1, 0, pat(8'h10), z, 0, "cnt_flush_a");
    for (int i = 0; i < 2; i++) step(0, 0, 1, pat(8'h11), z, 0, "cnt_stall");
    for (int i = 0; i < 3; i++) step(0, 1, 0, pat(8'h12), z, 0, "cnt_flush_b");
    n_checks++;
    if (BubbleCountE === 32'd8) n_pass++;
    else $display("FAIL cnt_total: got %0d, required 8", BubbleCountE);
    dut.bubble_cnt = 32'hFFFF_FFFF;
    exp_bc = 32'hFFFF_FFFF;
    step(0, 1, 0, pat(8'h13), z, 0, "cnt_saturate");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
